// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the 16x8 memory burst initiator.
// Contents:
//   OP_WR / OP_RD : command opcodes carried on cmd_op
//   state_t       : burst FSM state encoding, also exported on the debug port
package mem_ctrl_pkg;

  localparam logic OP_WR = 1'b0;
  localparam logic OP_RD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_CAPT  = 3'd3,
    ST_RD_HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/mem16x8_initiator_if.sv
// Host-side bus of the memory burst initiator: command, write-data and
// read-data channels.
//
// Handshake rule (all three channels): a transfer happens at a rising clock
// edge where valid and ready are both high. The producer holds its payload
// stable while valid is high and ready is low.
//
// Modports:
//   master : the host issuing commands, supplying write data, taking read data
//   slave  : the initiator block
interface mem16x8_initiator_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;

  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;

  logic              rdata_valid;
  logic              rdata_ready;
  logic [DATA_W-1:0] rdata;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready,
    input  cmd_ready, wdata_ready, rdata_valid, rdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready,
    output cmd_ready, wdata_ready, rdata_valid, rdata
  );

endinterface

// File: rtl/mem_burst_ctr.sv
// Burst address / remaining-beat counter.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   load               : capture load_addr / load_len (start of burst)
//   step               : advance one beat (address +1 with wrap, count -1)
//   load_addr/load_len : burst start address and beats-minus-one
//   addr               : current beat address
//   last               : high when the current beat is the final one
module mem_burst_ctr #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W-1:0] load_len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cnt_q;

  // Address wraps naturally at 2**ADDR_W through the fixed register width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      addr_q <= load_addr;
      cnt_q  <= load_len;
    end else if (step) begin
      addr_q <= addr_q + 1'b1;
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  assign addr = addr_q;
  assign last = (cnt_q == '0);

endmodule

// File: rtl/mem16x8_initiator.sv
// Burst initiator for a 2**ADDR_W x DATA_W synchronous memory.
// Accepts write or read burst commands and moves 1..2**ADDR_W beats between
// the host channels and the memory port.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : host command / write-data / read-data channels (slave side)
//   busy       : high whenever the FSM is not idle
//   done       : one-cycle pulse in the cycle after a burst's last beat
//   mem_we     : memory write strobe
//   mem_addr   : memory address (registered by the memory every cycle)
//   mem_data   : memory write data
//   mem_out    : memory read data, valid one cycle after mem_addr
//   dbg_state  : current FSM state
module mem16x8_initiator
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mem16x8_initiator_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_out,
  output state_t            dbg_state
);

  state_t            state_q, state_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rdata_q;
  logic              ctr_load, ctr_step, ctr_last;
  logic [ADDR_W-1:0] addr_q;

  mem_burst_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ctr_load),
    .step      (ctr_step),
    .load_addr (bus.cmd_addr),
    .load_len  (bus.cmd_len),
    .addr      (addr_q),
    .last      (ctr_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      // Memory output for the issued address is valid during RD_CAPT.
      if (state_q == ST_RD_CAPT) rdata_q <= mem_out;
    end
  end

  always_comb begin
    state_d         = state_q;
    done_d          = 1'b0;
    ctr_load        = 1'b0;
    ctr_step        = 1'b0;
    bus.cmd_ready   = 1'b0;
    bus.wdata_ready = 1'b0;
    bus.rdata_valid = 1'b0;
    mem_we          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          ctr_load = 1'b1;
          state_d  = (bus.cmd_op == OP_RD) ? ST_RD_ISSUE : ST_WR;
        end
      end
      ST_WR: begin
        bus.wdata_ready = 1'b1;
        // A reset arriving mid-beat must not let that beat reach memory.
        mem_we = bus.wdata_valid & rst_n;
        if (bus.wdata_valid) begin
          ctr_step = 1'b1;
          if (ctr_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_CAPT;
      ST_RD_CAPT:  state_d = ST_RD_HOLD;
      ST_RD_HOLD: begin
        bus.rdata_valid = 1'b1;
        if (bus.rdata_ready) begin
          if (ctr_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            ctr_step = 1'b1;
            state_d  = ST_RD_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign mem_addr  = addr_q;
  assign mem_data  = bus.wdata;
  assign bus.rdata = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem16x8_initiator.sv
// Testbench for mem16x8_initiator: directed bursts (wrap, gaps, stalls,
// pending command, reset abort) followed by random bursts, checked against a
// reference memory array and an expected read-data queue.
module tb_mem16x8_initiator;
  import mem_ctrl_pkg::*;

  localparam int AW       = 4;
  localparam int DW       = 8;
  localparam int DEPTH    = 16;
  localparam int NO_STALL = 99;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          busy, done, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_out;
  state_t        dbg_state;
  logic          mem_init = 1'b1;

  mem16x8_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem16x8_initiator #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_out   (mem_out),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Synchronous memory attached to the DUT's memory port.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i * 37 + 5);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_data;
    end
    mem_out <= mem[mem_addr];
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wbuf [DEPTH];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  // ---------------- driver tasks ----------------
  // Returns at the falling edge where the command is seen accepted-to-be
  // (cmd_valid and cmd_ready high); the acceptance edge is the next rise.
  task automatic issue_cmd(input logic op, input int a, input int len);
    int n;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = AW'(a);
    bus.cmd_len   = AW'(len);
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      chk("cmd_accept_timeout", 32'd0, 32'd1);
      report();
    end
  endtask

  // gap < 0: random wdata_valid gaps; otherwise exactly 'gap' idle cycles
  // before each beat.
  task automatic write_beats(input int a, input int len, input int gap);
    int  cur, beat, idle;
    logic v;
    cur  = a;
    beat = 0;
    idle = (gap < 0) ? 0 : gap;
    while (beat <= len) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      v = (gap < 0) ? ($urandom_range(0, 3) != 0) : (idle == 0);
      bus.wdata_valid = v;
      bus.wdata       = wbuf[beat];
      #1;
      chk("wr_busy", busy, 1);
      chk("wr_cmd_ready", bus.cmd_ready, 0);
      chk("wr_wdata_ready", bus.wdata_ready, 1);
      chk("wr_we", mem_we, v);
      chk("wr_addr", mem_addr, cur);
      chk("wr_done_early", done, 0);
      if (v) begin
        chk("wr_data", mem_data, wbuf[beat]);
        ref_mem[cur] = wbuf[beat];
        cur  = (cur + 1) % DEPTH;
        beat++;
        idle = (gap < 0) ? 0 : gap;
      end else begin
        idle--;
      end
    end
    @(negedge clk);
    bus.wdata_valid = 1'b0;
    #1;
    chk("wr_done", done, 1);
    chk("wr_busy_end", busy, 0);
    chk("wr_we_idle", mem_we, 0);
    chk("wr_cmd_ready_end", bus.cmd_ready, 1);
    @(negedge clk);
    chk("wr_done_pulse", done, 0);
  endtask

  // stall_beat < 0: random 0..2 stall cycles per beat; otherwise stall_n
  // cycles of rdata_ready low on beat stall_beat only. hold_next keeps
  // cmd_valid high with a new command (nop/naddr/nlen) through the burst.
  task automatic read_beats(input int a, input int len, input int stall_beat,
                            input int stall_n, input bit hold_next,
                            input logic nop, input int naddr, input int nlen);
    int cur, n, st;
    logic [DW-1:0] held, exp;
    cur = a;
    for (int b = 0; b <= len; b++) exp_q.push_back(ref_mem[(a + b) % DEPTH]);
    for (int b = 0; b <= len; b++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (b == 0 && n == 1) begin
          if (hold_next) begin
            bus.cmd_op   = nop;
            bus.cmd_addr = AW'(naddr);
            bus.cmd_len  = AW'(nlen);
          end else begin
            bus.cmd_valid = 1'b0;
          end
        end
        chk("rd_cmd_ready_busy", bus.cmd_ready, 0);
        chk("rd_busy", busy, 1);
      end while (!bus.rdata_valid && n < 20);
      chk("rd_latency", n, 3);
      if (!bus.rdata_valid) report();
      st = (stall_beat < 0) ? $urandom_range(0, 2) : ((b == stall_beat) ? stall_n : 0);
      held = bus.rdata;
      while (st > 0) begin
        bus.rdata_ready = 1'b0;
        @(negedge clk);
        st--;
        chk("rd_stall_valid", bus.rdata_valid, 1);
        chk("rd_stall_data", bus.rdata, held);
        chk("rd_stall_addr", mem_addr, cur);
      end
      exp = exp_q.pop_front();
      chk("rd_data", bus.rdata, exp);
      chk("rd_addr", mem_addr, cur);
      bus.rdata_ready = 1'b1;
      cur = (cur + 1) % DEPTH;
    end
    @(negedge clk);
    bus.rdata_ready = 1'b0;
    chk("rd_done", done, 1);
    chk("rd_busy_end", busy, 0);
    chk("rd_valid_end", bus.rdata_valid, 0);
    chk("rd_cmd_ready_done", bus.cmd_ready, 1);
    if (!hold_next) begin
      @(negedge clk);
      chk("rd_done_pulse", done, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_len     = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    bus.rdata_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i * 37 + 5);

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_rvalid", bus.rdata_valid, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst_n    = 1'b1;
    mem_init = 1'b0;

    // Write burst wrapping 14,15,0,1.
    for (int i = 0; i < 4; i++) wbuf[i] = 8'(8'hA0 + i);
    issue_cmd(OP_WR, 14, 3);
    write_beats(14, 3, 0);

    // Read the same burst back, ready held high.
    issue_cmd(OP_RD, 14, 3);
    read_beats(14, 3, NO_STALL, 0, 1'b0, 1'b0, 0, 0);

    // Stall beat 1 (address 15) for 5 cycles.
    issue_cmd(OP_RD, 14, 3);
    read_beats(14, 3, 1, 5, 1'b0, 1'b0, 0, 0);

    // Single-beat write with a 2-cycle data gap.
    wbuf[0] = 8'h5A;
    issue_cmd(OP_WR, 0, 0);
    write_beats(0, 0, 2);

    // Command pending through a busy read, taken in the done cycle.
    issue_cmd(OP_RD, 14, 1);
    read_beats(14, 1, NO_STALL, 0, 1'b1, OP_RD, 3, 0);
    read_beats(3, 0, NO_STALL, 0, 1'b0, 1'b0, 0, 0);

    // Reset during beat 1 of a 4-beat write.
    issue_cmd(OP_WR, 6, 3);
    @(negedge clk);
    bus.cmd_valid   = 1'b0;
    bus.wdata_valid = 1'b1;
    bus.wdata       = 8'h11;
    #1;
    chk("abort_we_beat0", mem_we, 1);
    chk("abort_addr_beat0", mem_addr, 6);
    ref_mem[6] = 8'h11;
    @(negedge clk);
    bus.wdata = 8'h22;
    rst_n     = 1'b0;
    #1;
    chk("abort_we_in_reset", mem_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_we_after", mem_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_rdata", bus.rdata, 0);
    chk("abort_rvalid", bus.rdata_valid, 0);
    chk("abort_state", dbg_state, ST_IDLE);
    @(negedge clk);
    chk("abort_no_done", done, 0);
    chk("abort_we_idle", mem_we, 0);
    bus.wdata_valid = 1'b0;

    // Random bursts.
    for (int k = 0; k < 25; k++) begin
      int a;
      int l;
      a = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 1) == 1) begin
        issue_cmd(OP_RD, a, l);
        read_beats(a, l, -1, 0, 1'b0, 1'b0, 0, 0);
      end else begin
        for (int i = 0; i < DEPTH; i++) wbuf[i] = 8'($urandom);
        issue_cmd(OP_WR, a, l);
        write_beats(a, l, -1);
      end
    end

    // Memory contents against the reference image.
    repeat (2) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) chk("mem_image", mem[i], ref_mem[i]);

    report();
  end

  initial begin
    #500000;
    chk("global_timeout", 32'd0, 32'd1);
    report();
  end

endmodule
